// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: streams operand pairs into a pipelined MAC one element
// at a time and returns bias plus the VEC_LEN-element dot product.
module mac_dot_sequencer #(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16,
    parameter int VEC_LEN   = 9,
    parameter int MAC_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ACC_WIDTH-1:0] bias,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_WIDTH-1:0] result,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_a,
    input  logic [IN_WIDTH-1:0]  in_b,
    output logic                 mac_en,
    output logic [IN_WIDTH-1:0]  mac_a,
    output logic [IN_WIDTH-1:0]  mac_b,
    output logic [ACC_WIDTH-1:0] mac_acc_in,
    input  logic [ACC_WIDTH-1:0] mac_acc_out
);

    localparam int WCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [7:0]     LAST  = 8'(VEC_LEN - 1);
    localparam logic [WCW-1:0] WLOAD = WCW'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [IN_WIDTH-1:0]  a_q, a_d;
    logic [IN_WIDTH-1:0]  b_q, b_d;
    logic [ACC_WIDTH-1:0] ain_q, ain_d;
    logic [ACC_WIDTH-1:0] res_q, res_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    // Next-state, datapath capture and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        ain_d   = ain_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    acc_d   = bias;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    ain_d   = acc_q;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = WLOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    acc_d = mac_acc_out;
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end
            S_DONE: begin
                res_d   = acc_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_q == S_DONE);
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ain_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ain_q   <= ain_d;
            res_q   <= res_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready   = (state_q == S_FETCH);
    assign mac_en     = (state_q == S_ISSUE);
    assign mac_a      = a_q;
    assign mac_b      = b_q;
    assign mac_acc_in = ain_q;
    assign result     = res_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: drives dot products through the sequencer and a
// behavioural two-stage MAC, checking results and timing against arithmetic.
module tb_mac_dot_sequencer;

    localparam int IW = 8;
    localparam int AW = 16;
    localparam int VL = 3;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] bias = '0;
    logic          busy, done, in_ready, mac_en;
    logic [AW-1:0] result, mac_acc_in, mac_acc_out;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_a = '0, in_b = '0;
    logic [IW-1:0] mac_a, mac_b;

    int checks = 0;
    int failures = 0;

    mac_dot_sequencer #(
        .IN_WIDTH (IW),
        .ACC_WIDTH(AW),
        .VEC_LEN  (VL),
        .MAC_LAT  (ML)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bias       (bias),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mac_en     (mac_en),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_acc_in (mac_acc_in),
        .mac_acc_out(mac_acc_out)
    );

    always #5 clk = ~clk;

    // Stand-in for the pipelined MAC: sum visible two cycles after issue.
    logic [AW-1:0] m_s1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1        <= '0;
            mac_acc_out <= '0;
        end else begin
            if (mac_en) m_s1 <= mac_acc_in + AW'(mac_a) * AW'(mac_b);
            mac_acc_out <= m_s1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int en_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (mac_en) en_cnt++;
        if (done) done_cnt++;
    end

    logic [IW-1:0] va[VL];
    logic [IW-1:0] vb[VL];
    int            vs[VL];

    function automatic logic [AW-1:0] ref_dot(input logic [AW-1:0] b0);
        logic [31:0] s;
        s = 32'(b0);
        for (int i = 0; i < VL; i++) s = s + 32'(va[i]) * 32'(vb[i]);
        return s[AW-1:0];
    endfunction

    function automatic int ref_lat();
        int l;
        l = 1 + (2 + ML) * VL;
        for (int i = 0; i < VL; i++) l += vs[i];
        return l;
    endfunction

    task automatic run_dot(input logic [AW-1:0] b0, input bit pulse_wait,
                           output logic [AW-1:0] res, output int lat,
                           output int ens, output bit ok);
        int e0, s, t;
        ok = 1'b1;
        e0 = en_cnt;
        bias = b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = cyc;
        bias = AW'($urandom);
        for (int i = 0; i < VL; i++) begin
            in_a = va[i];
            in_b = vb[i];
            in_valid = (vs[i] == 0);
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                ok = 1'b0;
                break;
            end
            for (int k = 0; k < vs[i]; k++) begin
                if (in_ready !== 1'b1) ok = 1'b0;
                @(negedge clk);
            end
            if (in_ready !== 1'b1) ok = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            if (pulse_wait && i == 1) begin
                in_valid = 1'b0;
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!done) ok = 1'b0;
        lat = cyc - s;
        res = result;
        ens = en_cnt - e0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        in_a = 8'h5A;
        in_b = 8'hA5;
        bias = 16'h1234;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({busy, done, in_ready, mac_en} !== 4'b0) begin
                failures++;
                $display("FAIL reset_ctl: got %b want 0000",
                         {busy, done, in_ready, mac_en});
            end
            checks++;
            if ({result, mac_a, mac_b, mac_acc_in} !== '0) begin
                failures++;
                $display("FAIL reset_data: res=%h a=%h b=%h ai=%h want 0",
                         result, mac_a, mac_b, mac_acc_in);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (en_cnt !== 0 || done_cnt !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_quiet: en=%0d done=%0d busy=%b want 0 0 0",
                     en_cnt, done_cnt, busy);
        end
    endtask

    task automatic check_run(input string name, input logic [AW-1:0] b0,
                             input bit pulse_wait);
        logic [AW-1:0] res, exp;
        int lat, ens;
        bit ok;
        exp = ref_dot(b0);
        run_dot(b0, pulse_wait, res, lat, ens, ok);
        checks++;
        if (res !== exp || !ok) begin
            failures++;
            $display("FAIL %s_result: got %h ok=%0d want %h ok=1",
                     name, res, ok, exp);
        end
        checks++;
        if (lat !== ref_lat() || ens !== VL) begin
            failures++;
            $display("FAIL %s_timing: lat=%0d en=%0d want lat=%0d en=%0d",
                     name, lat, ens, ref_lat(), VL);
        end
    endtask

    task automatic test_basic();
        va = '{8'd3, 8'd5, 8'd1};
        vb = '{8'd4, 8'd6, 8'd2};
        vs = '{0, 0, 0};
        check_run("basic", 16'd10, 1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'd54) begin
            failures++;
            $display("FAIL basic_after: busy=%b done=%b res=%0d want 0 0 54",
                     busy, done, result);
        end
    endtask

    task automatic test_backpressure();
        va = '{8'd3, 8'd5, 8'd1};
        vb = '{8'd4, 8'd6, 8'd2};
        vs = '{0, 3, 0};
        check_run("stall", 16'd10, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        va = '{8'd4, 8'd0, 8'd0};
        vb = '{8'd5, 8'd0, 8'd0};
        vs = '{0, 0, 0};
        check_run("wrap", 16'hFFF0, 1'b0);
        checks++;
        if (result !== 16'h0004) begin
            failures++;
            $display("FAIL wrap_value: got %h want 0004", result);
        end
        @(negedge clk);
    endtask

    task automatic test_ignored();
        int e0, d0;
        bit rdy_seen;
        logic [IW-1:0] a0;
        e0 = en_cnt;
        a0 = mac_a;
        rdy_seen = 1'b0;
        in_valid = 1'b1;
        in_a = 8'd9;
        in_b = 8'd9;
        repeat (3) begin
            @(negedge clk);
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (rdy_seen || en_cnt !== e0 || mac_a !== a0) begin
            failures++;
            $display("FAIL idle_valid: rdy=%0d en=%0d a=%h want 0 %0d %h",
                     rdy_seen, en_cnt, mac_a, e0, a0);
        end
        for (int i = 0; i < VL; i++) begin
            va[i] = IW'($urandom);
            vb[i] = IW'($urandom);
            vs[i] = 0;
        end
        d0 = done_cnt;
        check_run("start_in_wait", AW'($urandom), 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_in_wait_pulses: got %0d busy=%b want 1 0",
                     done_cnt - d0, busy);
        end
    endtask

    task automatic test_back_to_back();
        va = '{8'd3, 8'd5, 8'd1};
        vb = '{8'd4, 8'd6, 8'd2};
        vs = '{0, 0, 0};
        check_run("b2b_first", 16'd10, 1'b0);
        for (int i = 0; i < VL; i++) begin
            va[i] = IW'($urandom);
            vb[i] = IW'($urandom);
        end
        check_run("b2b_second", AW'($urandom), 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        bias = 16'd777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_a = 8'd200;
        in_b = 8'd100;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        in_a = 8'd250;
        in_b = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== '0 || mac_en !== 1'b0 ||
            done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: busy=%b res=%h en=%b done=%b want 0",
                     busy, result, mac_en, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin
            failures++;
            $display("FAIL mid_reset_done: got %0d pulses want 0",
                     done_cnt - d0);
        end
        va = '{8'd3, 8'd5, 8'd1};
        vb = '{8'd4, 8'd6, 8'd2};
        vs = '{0, 0, 0};
        check_run("post_reset", 16'd10, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < VL; i++) begin
                va[i] = IW'($urandom);
                vb[i] = IW'($urandom);
                vs[i] = int'($urandom_range(0, 3));
            end
            check_run("random", AW'($urandom), 1'b0);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Initiator-side controller for the two-stage pipelined MAC unit.
- Accepts a stream of operand pairs over a valid/ready handshake and issues one MAC operation per element, chaining the running sum through the MAC's acc_in/acc_out ports.
- Returns a VEC_LEN-element dot product plus bias, for example one 3x3 kernel window of the CNN accelerator.
- Sits between the line-buffer/weight fetch logic and a mac_unit_pipelined instance.

Parameters:
IN_WIDTH, 8, operand width of a and b.
ACC_WIDTH, 16, accumulator/result width.
VEC_LEN, 9, elements per dot product (legal range 1 to 255).
MAC_LAT, 2, MAC latency in cycles from the operand-sampling edge to a valid mac_acc_out.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin a dot product; sampled only in IDLE.
bias  in  ACC_WIDTH  initial accumulator value; latched on accepted start.
busy  out  1  high from accepted start until done, inclusive.
done  out  1  one-cycle pulse when result is updated.
result  out  ACC_WIDTH  final sum; held until the next done.
in_valid  in  1  operand pair valid.
in_ready  out  1  sequencer can accept an operand pair.
in_a  in  IN_WIDTH  operand a.
in_b  in  IN_WIDTH  operand b.
mac_en  out  1  to MAC en.
mac_a  out  IN_WIDTH  to MAC a.
mac_b  out  IN_WIDTH  to MAC b.
mac_acc_in  out  ACC_WIDTH  to MAC acc_in.
mac_acc_out  in  ACC_WIDTH  from MAC acc_out.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; element counter, wait counter and acc_reg clear to 0.
  - busy, done, in_ready and mac_en are 0; result, mac_a, mac_b and mac_acc_in are 0.
  - Reset mid-operation abandons the operation and does not assert done. The MAC is reset by the same rst_n.
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 moves to FETCH, sets acc_reg<=bias and cnt<=0.
- FETCH:
  - in_ready=1, busy=1.
  - On in_valid&&in_ready: mac_a<=in_a, mac_b<=in_b, mac_acc_in<=acc_reg, then move to ISSUE.
  - in_valid low holds in FETCH indefinitely.
- ISSUE:
  - mac_en=1 for exactly this one cycle.
  - Moves to WAIT with wcnt<=MAC_LAT-1.
- WAIT:
  - mac_en=0.
  - Decrement wcnt each cycle. On the cycle with wcnt==0, capture acc_reg<=mac_acc_out.
  - Then go to DONE if cnt==VEC_LEN-1, else cnt<=cnt+1 and go to FETCH.
- DONE:
  - result<=acc_reg, done=1 for one cycle, busy=1.
  - Unconditionally returns to IDLE.
- Timing:
  - Operands are presented in the ISSUE cycle k; mac_acc_out is sampled in cycle k+MAC_LAT.
  - With in_valid held high, each element takes 2+MAC_LAT cycles.
  - done asserts (2+MAC_LAT)*VEC_LEN+1 cycles after the start-sampling edge; that is 13 cycles for VEC_LEN=3 and MAC_LAT=2.
- Only one operation is in flight in the MAC at any time; there is no overlap between elements.
- mac_a, mac_b and mac_acc_in hold their last values outside ISSUE.
- Arithmetic is unsigned and wraps modulo 2^ACC_WIDTH, taken as delivered by the MAC. The sequencer does no saturation.
- Ignored events:
  - start outside IDLE, including start during DONE.
  - in_valid outside FETCH; no handshake occurs.
- A start is accepted at the earliest one cycle after done.
- VEC_LEN=1: exactly one FETCH/ISSUE/WAIT pass, then DONE.

Test Plan:
1. Full-system reset: rst_n=0 for 2 cycles with start=1 and in_valid=1 -> all outputs 0, no mac_en pulse, done never high.
2. Basic dot product: VEC_LEN=3, bias=10, pairs (3,4),(5,6),(1,2), in_valid held 1 -> result=54, done exactly 13 cycles after start, mac_en pulses exactly 3 times, busy low after done.
3. Backpressure: same as test 2 but in_valid low for 3 cycles before the second pair -> result=54, done at cycle 16, in_ready high throughout the stall, no extra mac_en pulses.
4. Wrap-around: bias=16'hFFF0, pairs (4,5),(0,0),(0,0) -> result=16'h0004.
5. Ignored inputs:
   - start pulsed during WAIT -> no restart, result unchanged.
   - in_valid=1 while IDLE -> in_ready=0 and the pair is not consumed.
   - A new start in the cycle after done is accepted.
6. Reset mid-operation: rst_n low during WAIT of element 2 -> busy=0, result=0, mac_en=0 immediately. A following run of test 2 yields 54 with no stale contribution.
